// File: rtl/data_mem_initiator.sv
// rtl/data_mem_initiator.sv - load/store initiator for the memread/memwrite/clk_stall data memory
module data_mem_initiator #(
  parameter bit SPLIT_MISALIGNED = 1'b1,
  parameter int STALL_TIMEOUT    = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [13:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [13:0] mem_addr,
  output logic [31:0] mem_write_data,
  output logic        mem_memwrite,
  output logic        mem_memread,
  output logic [3:0]  mem_sign_mask,
  input  logic [31:0] mem_read_data,
  input  logic        mem_clk_stall
);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT_HI, S_WAIT_LO, S_DONE} state_t;

  localparam logic [1:0]  SZ_BYTE  = 2'b00;
  localparam logic [1:0]  SZ_HALF  = 2'b01;
  localparam logic [1:0]  SZ_WORD  = 2'b10;
  localparam logic [15:0] TMO_LAST = 16'(STALL_TIMEOUT - 1);

  state_t      state_q, state_d;
  logic        write_q, write_d;
  logic [13:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  size_q, size_d;
  logic        signed_q, signed_d;
  logic        split_q, split_d;
  logic [1:0]  piece_q, piece_d;
  logic [1:0]  last_q, last_d;
  logic [31:0] rbuf_q, rbuf_d;
  logic        err_q, err_d;
  logic [15:0] tcnt_q, tcnt_d;

  logic [13:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_mask_q, mem_mask_d;
  logic        mem_read_q, mem_read_d;
  logic        mem_write_q, mem_write_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        resp_err_q, resp_err_d;

  logic [1:0]  in_size;
  logic        in_misaligned;
  logic [13:0] src_addr;
  logic [31:0] src_wdata;
  logic [1:0]  src_size;
  logic        src_signed;
  logic        src_split;
  logic [1:0]  src_piece;
  logic [13:0] iss_addr;
  logic [31:0] iss_wdata;
  logic [3:0]  iss_mask;
  logic [31:0] ext_rdata;

  assign req_ready      = (state_q == S_IDLE) & ~mem_clk_stall;
  assign resp_valid     = resp_valid_q;
  assign resp_rdata     = resp_rdata_q;
  assign resp_err       = resp_err_q;
  assign mem_addr       = mem_addr_q;
  assign mem_write_data = mem_wdata_q;
  assign mem_memwrite   = mem_write_q;
  assign mem_memread    = mem_read_q;
  assign mem_sign_mask  = mem_mask_q;

  // Normalise size (11 behaves as word) and flag accesses the memory cannot serve in one go
  always_comb begin
    in_size       = (req_size == 2'b11) ? SZ_WORD : req_size;
    in_misaligned = ((in_size == SZ_HALF) && req_addr[0]) ||
                    ((in_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
  end

  // Memory-side fields of the next piece: request inputs on accept, latched request advanced by one otherwise
  always_comb begin
    if (state_q == S_IDLE) begin
      src_addr   = req_addr;
      src_wdata  = req_wdata;
      src_size   = in_size;
      src_signed = req_signed;
      src_split  = in_misaligned;
      src_piece  = 2'd0;
    end else begin
      src_addr   = addr_q;
      src_wdata  = wdata_q;
      src_size   = size_q;
      src_signed = signed_q;
      src_split  = split_q;
      src_piece  = piece_q + 2'd1;
    end
    iss_addr = src_addr + {12'b0, src_piece};
    if (src_split) begin
      iss_mask  = 4'b0001;
      iss_wdata = {24'b0, 8'(src_wdata >> {src_piece, 3'b000})};
    end else begin
      iss_wdata = src_wdata;
      case (src_size)
        SZ_BYTE: iss_mask = {src_signed, 3'b001};
        SZ_HALF: iss_mask = {src_signed, 3'b011};
        default: iss_mask = {src_signed, 3'b111};
      endcase
    end
  end

  // Final load result: zero/sign extension of the captured or reassembled data
  always_comb begin
    case (size_q)
      SZ_BYTE: ext_rdata = {{24{signed_q & rbuf_q[7]}}, rbuf_q[7:0]};
      SZ_HALF: ext_rdata = {{16{signed_q & rbuf_q[15]}}, rbuf_q[15:0]};
      default: ext_rdata = rbuf_q;
    endcase
  end

  // Next-state and registered-output logic of the request FSM
  always_comb begin
    state_d      = state_q;
    write_d      = write_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    size_d       = size_q;
    signed_d     = signed_q;
    split_d      = split_q;
    piece_d      = piece_q;
    last_d       = last_q;
    rbuf_d       = rbuf_q;
    err_d        = err_q;
    tcnt_d       = tcnt_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_mask_d   = mem_mask_q;
    mem_read_d   = 1'b0;
    mem_write_d  = 1'b0;
    resp_valid_d = 1'b0;
    resp_rdata_d = 32'h0;
    resp_err_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready) begin
          write_d  = req_write;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          size_d   = in_size;
          signed_d = req_signed;
          split_d  = in_misaligned;
          piece_d  = 2'd0;
          rbuf_d   = 32'h0;
          err_d    = 1'b0;
          last_d   = !in_misaligned ? 2'd0 : ((in_size == SZ_HALF) ? 2'd1 : 2'd3);
          if (in_misaligned && !SPLIT_MISALIGNED) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d     = S_ISSUE;
            mem_addr_d  = iss_addr;
            mem_wdata_d = iss_wdata;
            mem_mask_d  = iss_mask;
            mem_read_d  = ~req_write;
            mem_write_d = req_write;
          end
        end
      end
      S_ISSUE: begin
        tcnt_d  = 16'h0;
        state_d = S_WAIT_HI;
      end
      S_WAIT_HI: begin
        if (mem_clk_stall) begin
          state_d = S_WAIT_LO;
        end else if (tcnt_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          tcnt_d = tcnt_q + 16'd1;
        end
      end
      S_WAIT_LO: begin
        if (!mem_clk_stall) begin
          if (!write_q) begin
            if (split_q) rbuf_d[{piece_q, 3'b000} +: 8] = mem_read_data[7:0];
            else         rbuf_d = mem_read_data;
          end
          if (piece_q != last_q) begin
            piece_d     = piece_q + 2'd1;
            state_d     = S_ISSUE;
            mem_addr_d  = iss_addr;
            mem_wdata_d = iss_wdata;
            mem_mask_d  = iss_mask;
            mem_read_d  = ~write_q;
            mem_write_d = write_q;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        resp_valid_d = 1'b1;
        resp_err_d   = err_q;
        resp_rdata_d = (write_q || err_q) ? 32'h0 : ext_rdata;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset drops every output but leaves the memory to finish on its own
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      write_q      <= 1'b0;
      addr_q       <= 14'h0;
      wdata_q      <= 32'h0;
      size_q       <= 2'b00;
      signed_q     <= 1'b0;
      split_q      <= 1'b0;
      piece_q      <= 2'd0;
      last_q       <= 2'd0;
      rbuf_q       <= 32'h0;
      err_q        <= 1'b0;
      tcnt_q       <= 16'h0;
      mem_addr_q   <= 14'h0;
      mem_wdata_q  <= 32'h0;
      mem_mask_q   <= 4'h0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'h0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      write_q      <= write_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      size_q       <= size_d;
      signed_q     <= signed_d;
      split_q      <= split_d;
      piece_q      <= piece_d;
      last_q       <= last_d;
      rbuf_q       <= rbuf_d;
      err_q        <= err_d;
      tcnt_q       <= tcnt_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_mask_q   <= mem_mask_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

endmodule

// File: doc/data_mem_initiator.md
Name: data_mem_initiator

Overview:
Core-side initiator for the data memory's memread/memwrite/clk_stall protocol. It accepts one load/store request at a time from the pipeline and drives the data memory's request signals. It waits out the memory's stall window and returns the read data with a completion pulse. Misaligned halfword and word accesses, which the memory cannot serve in one transaction, are split into sequential unsigned byte transactions and reassembled here.

Parameters:
SPLIT_MISALIGNED, 1, 1 = split misaligned accesses into byte transactions; 0 = reject them with resp_err
STALL_TIMEOUT, 15, cycles allowed in WAIT_HI for mem_clk_stall to rise before aborting with resp_err

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  block is IDLE and the memory is not stalling
req_write  input  1  1 = store, 0 = load
req_addr  input  14  byte address
req_wdata  input  32  store data, right-aligned
req_size  input  2  00 byte, 01 half, 10 word, 11 treated as word
req_signed  input  1  sign-extend load result
resp_valid  output  1  one-cycle completion pulse, for loads and stores
resp_rdata  output  32  load result, valid with resp_valid; 0 for stores
resp_err  output  1  valid with resp_valid: timeout or rejected misaligned request
mem_addr  output  14  to memory addr
mem_write_data  output  32  to memory write_data
mem_memwrite  output  1  to memory memwrite
mem_memread  output  1  to memory memread
mem_sign_mask  output  4  to memory sign_mask
mem_read_data  input  32  from memory read_data
mem_clk_stall  input  1  from memory clk_stall

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; all outputs 0 immediately.
  - Reset does not abort a memory-side transaction already in flight.
- req_ready = (state==IDLE) & ~mem_clk_stall. A request is accepted on a clk edge when req_valid & req_ready.
- sign_mask encoding: {signed, 3'b001} byte, {signed, 3'b011} half, {signed, 3'b111} word.
- Misaligned: half with addr[0]=1; word with addr[1:0]!=0.
  - Aligned requests run as one piece, with the request's own sign_mask and data.
  - Misaligned requests with SPLIT_MISALIGNED=1 run as N pieces: N=2 for half, N=4 for word.
  - Piece k: mem_addr = (req_addr+k) mod 2^14; sign_mask 4'b0001; write_data = {24'b0, wdata byte k}.
  - On a load, the low byte of read_data is placed in result lane k.
- Misaligned with SPLIT_MISALIGNED=0: no memory access; resp_valid with resp_err=1 on the cycle after acceptance.
- States: IDLE, ISSUE, WAIT_HI, WAIT_LO, DONE. All outputs are registered.
  - IDLE -> ISSUE on accept. Request fields are latched; piece counter is cleared.
  - ISSUE: mem_memread or mem_memwrite is high for exactly one cycle, with addr/data/sign_mask stable -> WAIT_HI. Strobes are never both high.
  - WAIT_HI: wait for mem_clk_stall=1, then -> WAIT_LO. After STALL_TIMEOUT cycles without it -> DONE with err=1.
  - WAIT_LO: on a sample of mem_clk_stall=0, a load captures mem_read_data. If pieces remain: counter+1 -> ISSUE. Otherwise -> DONE.
  - DONE: resp_valid=1 for one cycle -> IDLE.
    - resp_rdata for word: the assembled value.
    - resp_rdata for half: bits[15:0], zero- or sign-extended from bit 15.
    - resp_rdata for byte: bits[7:0], zero- or sign-extended from bit 7.
- Latency: an aligned piece takes 4 cycles from ISSUE entry to its WAIT_LO exit. resp_valid is high 5 cycles after the accept edge. A misaligned word takes 4 pieces, so resp_valid comes 17 cycles after accept.
- Address 14'h2000 (LED register) is passed through as an ordinary aligned access.
- Wrap-around: piece addresses wrap modulo 2^14, e.g. 14'h3FFF+1 = 14'h0000.
- A new request is never accepted on the same edge that resp_valid is pulsed.

Test Plan:
- Aligned word load at 14'h1004, memory word 32'hDEADBEEF -> one memread pulse; resp_valid 5 cycles after accept; resp_rdata=32'hDEADBEEF; resp_err=0.
- Signed byte load at 14'h1003, byte 8'h80 -> mem_sign_mask=4'b1001; resp_rdata=32'hFFFFFF80.
- Misaligned word store 32'h11223344 at 14'h1001 -> four byte writes to 1001..1004 with data 44,33,22,11. A following aligned load at 1000 returns {22,33,44,old byte0}; load at 1004 returns low byte 11.
- Misaligned signed half load at 14'h1003, bytes 8'hFE then 8'h8F -> two byte reads; resp_rdata=32'hFFFF8FFE.
- mem_clk_stall tied 0 -> resp_valid after STALL_TIMEOUT+2 cycles in WAIT_HI, with resp_err=1. Then SPLIT_MISALIGNED=0 and a misaligned half load -> no strobe; resp_err=1 on the cycle after accept.
- rst_n pulsed low in WAIT_HI -> outputs 0 immediately; req_ready stays 0 until mem_clk_stall=0; the next request completes normally.
